// File: rtl/dmem_axi_bridge.sv
// Data-side bridge: one CPU memory-stage access -> one single-beat AXI3 read or write.
// Optional DMEM_KSEG_MAP_EN: fold kseg0/kseg1 addresses onto physical space in the bridge.
module dmem_axi_bridge #(
  parameter logic [3:0]  AXI_ID = 4'd1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_en,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic              ext_stall,
  output logic [31:0]       data_rdata,
  output logic              d_stall,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addrReg;
  logic [31:0]       wdataReg;
  logic [3:0]        wstrbReg;
  logic [2:0]        awsizeReg;
  logic [31:0]       rdataReg;
  logic              awDone;
  logic              wDone;
  logic              awHs;
  logic              wHs;
  logic [2:0]        sizeFromStrb;
  logic              unusedSigs;

  function automatic logic [ADDR_W-1:0] mapAddr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
`ifdef DMEM_KSEG_MAP_EN
    // kseg0 (100) and kseg1 (101) share the top two bits 2'b10
    if (a[ADDR_W-1 -: 2] == 2'b10) r = {3'b000, a[ADDR_W-4:0]};
`endif
    return r;
  endfunction

  always_comb begin
    case (data_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sizeFromStrb = 3'd0;
      4'b0011, 4'b1100:                   sizeFromStrb = 3'd1;
      default:                            sizeFromStrb = 3'd2;
    endcase
  end

  assign awHs = awvalid & awready;
  assign wHs  = wvalid & wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addrReg   <= '0;
      wdataReg  <= '0;
      wstrbReg  <= '0;
      awsizeReg <= '0;
      rdataReg  <= '0;
      awDone    <= 1'b0;
      wDone     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_en) begin
            addrReg <= data_addr;
            if (data_wen == 4'b0000) begin
              state <= RD_ADDR;
            end else begin
              wdataReg  <= data_wdata;
              wstrbReg  <= data_wen;
              awsizeReg <= sizeFromStrb;
              state     <= WR_REQ;
            end
          end
        end
        RD_ADDR: if (arready) state <= RD_DATA;
        RD_DATA: begin
          if (rvalid) begin
            rdataReg <= rdata;
            state    <= DONE;
          end
        end
        WR_REQ: begin
          // flags remember a channel that already handshook; both may close in one cycle
          if ((awDone | awHs) && (wDone | wHs)) begin
            awDone <= 1'b0;
            wDone  <= 1'b0;
            state  <= WR_RESP;
          end else begin
            awDone <= awDone | awHs;
            wDone  <= wDone | wHs;
          end
        end
        WR_RESP: if (bvalid) state <= DONE;
        DONE:    if (!ext_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign d_stall = ((state == IDLE) & data_en) | ((state != IDLE) & (state != DONE));

  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);
  assign awvalid = (state == WR_REQ) & ~awDone;
  assign wvalid  = (state == WR_REQ) & ~wDone;
  assign bready  = (state == WR_RESP);

  assign arid    = AXI_ID;
  assign araddr  = mapAddr({addrReg[ADDR_W-1:2], 2'b00});
  assign arlen   = 4'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign awid    = AXI_ID;
  assign awaddr  = mapAddr(addrReg);
  assign awlen   = 4'd0;
  assign awsize  = awsizeReg;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid     = AXI_ID;
  assign wdata   = wdataReg;
  assign wstrb   = wstrbReg;
  assign wlast   = 1'b1;

  assign data_rdata = rdataReg;

  // single-beat reads: the last flag carries no extra information
  assign unusedSigs = rlast;

endmodule
